// File: rtl/mips_bus_arbiter.sv
// Two-master, one-slave arbiter for the CPU memory bus (round-robin or fixed priority).
// Optional macro ARB_LOCK_EN adds per-master lock inputs for back-to-back locked transactions.
module mips_bus_arbiter #(
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
`ifdef ARB_LOCK_EN
  input  logic                m0_lock,
  input  logic                m1_lock,
`endif
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          grant
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;   // 0 = m0 owned last, 1 = m1 owned last
  logic   req0, req1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Read data is broadcast; only the owner's completion cycle is meaningful.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    s_address      = m0_address;
    s_writedata    = m0_writedata;
    s_byteenable   = m0_byteenable;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant          = 2'b00;

    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          if (PRIORITY_MODE != 0) state_d = GNT0;
          else                    state_d = last_grant_q ? GNT0 : GNT1;
        end else if (req0) begin
          state_d = GNT0;
        end else if (req1) begin
          state_d = GNT1;
        end
      end

      GNT0: begin
        grant          = 2'b01;
        s_read         = m0_read;
        s_write        = m0_write;
        m0_waitrequest = s_waitrequest;
        if (!req0) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
`ifdef ARB_LOCK_EN
          if (!m0_lock) begin
            state_d      = IDLE;
            last_grant_d = 1'b0;
          end
`else
          state_d      = IDLE;
          last_grant_d = 1'b0;
`endif
        end
      end

      GNT1: begin
        grant          = 2'b10;
        s_address      = m1_address;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        s_read         = m1_read;
        s_write        = m1_write;
        m1_waitrequest = s_waitrequest;
        if (!req1) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
`ifdef ARB_LOCK_EN
          if (!m1_lock) begin
            state_d      = IDLE;
            last_grant_d = 1'b1;
          end
`else
          state_d      = IDLE;
          last_grant_d = 1'b1;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench: a round-robin and a fixed-priority arbiter share one stimulus stream.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata, s_readdata;
  logic        m0_read, m0_write, m1_read, m1_write, s_waitrequest;
  logic [3:0]  m0_byteenable, m1_byteenable;
`ifdef ARB_LOCK_EN
  logic        m0_lock, m1_lock;
`endif

  logic        r_m0_wr, r_m1_wr, r_s_read, r_s_write;
  logic [31:0] r_m0_rd, r_m1_rd, r_s_address, r_s_writedata;
  logic [3:0]  r_s_be;
  logic [1:0]  r_grant;

  logic        p_m0_wr, p_m1_wr, p_s_read, p_s_write;
  logic [31:0] p_m0_rd, p_m1_rd, p_s_address, p_s_writedata;
  logic [3:0]  p_s_be;
  logic [1:0]  p_grant;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_accepts = 0;
  int acc_base;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.PRIORITY_MODE(0), .ADDR_W(32), .DATA_W(32)) u_rr (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(r_m0_wr), .m0_readdata(r_m0_rd),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(r_m1_wr), .m1_readdata(r_m1_rd),
`ifdef ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .s_address(r_s_address), .s_read(r_s_read), .s_write(r_s_write),
    .s_writedata(r_s_writedata), .s_byteenable(r_s_be),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .grant(r_grant)
  );

  mips_bus_arbiter #(.PRIORITY_MODE(1), .ADDR_W(32), .DATA_W(32)) u_pr (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(p_m0_wr), .m0_readdata(p_m0_rd),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(p_m1_wr), .m1_readdata(p_m1_rd),
`ifdef ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .s_address(p_s_address), .s_read(p_s_read), .s_write(p_s_write),
    .s_writedata(p_s_writedata), .s_byteenable(p_s_be),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .grant(p_grant)
  );

  // Slave-side write acceptances on the round-robin instance.
  always @(posedge clk)
    if (reset && r_s_write && !s_waitrequest) wr_accepts = wr_accepts + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_address = 32'h0; m1_address = 32'h0;
    m0_writedata = 32'h0; m1_writedata = 32'h0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    s_waitrequest = 1'b0; s_readdata = 32'h0;
`ifdef ARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    next();
    next();
    reset = 1'b1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #2;
    // Reset values
    chk("rst_grant", 32'(r_grant), 32'h0);
    chk("rst_m0_wait", 32'(r_m0_wr), 32'h1);
    chk("rst_m1_wait", 32'(r_m1_wr), 32'h1);
    chk("rst_s_read", 32'(r_s_read), 32'h0);
    chk("rst_s_write", 32'(r_s_write), 32'h0);
    next();
    reset = 1'b1;

    // m0 single read, zero-wait slave
    next();
    m0_read = 1'b1; m0_address = 32'hBFC00000; s_readdata = 32'h8C030004;
    #1;
    chk("t1_idle_wait", 32'(r_m0_wr), 32'h1);
    chk("t1_idle_sread", 32'(r_s_read), 32'h0);
    chk("t1_idle_grant", 32'(r_grant), 32'h0);
    chk("t1_idle_m1wait", 32'(r_m1_wr), 32'h1);
    next();
    #1;
    chk("t1_sread", 32'(r_s_read), 32'h1);
    chk("t1_saddr", r_s_address, 32'hBFC00000);
    chk("t1_wait0", 32'(r_m0_wr), 32'h0);
    chk("t1_rdata", r_m0_rd, 32'h8C030004);
    chk("t1_grant", 32'(r_grant), 32'h1);
    chk("t1_m1wait", 32'(r_m1_wr), 32'h1);
    next();
    m0_read = 1'b0;
    #1;
    chk("t1_done_grant", 32'(r_grant), 32'h0);
    chk("t1_done_wait", 32'(r_m0_wr), 32'h1);
    chk("t1_done_m1wait", 32'(r_m1_wr), 32'h1);

    // Simultaneous requests: RR alternates, fixed priority keeps m0
    idle_inputs();
    do_reset();
    m0_read = 1'b1; m1_read = 1'b1; m0_address = 32'h100; m1_address = 32'h200;
    for (int k = 0; k < 4; k++) begin
      next();
      #1;
      chk($sformatf("rr_grant%0d", k), 32'(r_grant), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("rr_addr%0d", k), r_s_address, (k % 2 == 0) ? 32'h100 : 32'h200);
      chk($sformatf("pr_grant%0d", k), 32'(p_grant), 32'h1);
      next();
      #1;
      chk($sformatf("rr_bubble%0d", k), 32'(r_grant), 32'h0);
      chk($sformatf("pr_bubble%0d", k), 32'(p_grant), 32'h0);
    end
    m0_read = 1'b0;
    next();
    #1;
    chk("pr_m1_grant", 32'(p_grant), 32'h2);
    chk("pr_m1_wait", 32'(p_m1_wr), 32'h0);
    chk("pr_m0_stall", 32'(p_m0_wr), 32'h1);
    next();
    m1_read = 1'b0;
    #1;
    chk("pr_end_grant", 32'(p_grant), 32'h0);

    // m1 write with three slave wait cycles
    idle_inputs();
    do_reset();
    m1_write = 1'b1; m1_address = 32'h10; m1_writedata = 32'h12345678;
    m1_byteenable = 4'b0011; s_waitrequest = 1'b1;
    acc_base = wr_accepts;
    #1;
    chk("t4_idle_grant", 32'(r_grant), 32'h0);
    for (int i = 0; i < 4; i++) begin
      next();
      if (i == 3) s_waitrequest = 1'b0;
      #1;
      chk($sformatf("t4_swrite%0d", i), 32'(r_s_write), 32'h1);
      chk($sformatf("t4_saddr%0d", i), r_s_address, 32'h10);
      chk($sformatf("t4_sdata%0d", i), r_s_writedata, 32'h12345678);
      chk($sformatf("t4_sbe%0d", i), 32'(r_s_be), 32'h3);
      chk($sformatf("t4_m1wait%0d", i), 32'(r_m1_wr), (i < 3) ? 32'h1 : 32'h0);
      chk($sformatf("t4_m0wait%0d", i), 32'(r_m0_wr), 32'h1);
    end
    next();
    m1_write = 1'b0;
    #1;
    chk("t4_end_grant", 32'(r_grant), 32'h0);
    chk("t4_end_swrite", 32'(r_s_write), 32'h0);
    chk("t4_accepts", 32'(wr_accepts - acc_base), 32'h1);

    // Reset pulsed mid-transaction
    idle_inputs();
    do_reset();
    m0_read = 1'b1; m0_address = 32'h40; s_waitrequest = 1'b1;
    next();
    #1;
    chk("t5_grant", 32'(r_grant), 32'h1);
    chk("t5_sread", 32'(r_s_read), 32'h1);
    reset = 1'b0;
    #1;
    chk("t5_rst_sread", 32'(r_s_read), 32'h0);
    chk("t5_rst_grant", 32'(r_grant), 32'h0);
    chk("t5_rst_wait", 32'(r_m0_wr), 32'h1);
    next();
    reset = 1'b1; s_waitrequest = 1'b0;
    #1;
    chk("t5_rel_grant", 32'(r_grant), 32'h0);
    chk("t5_rel_wait", 32'(r_m0_wr), 32'h1);
    next();
    #1;
    chk("t5_regrant", 32'(r_grant), 32'h1);
    chk("t5_re_sread", 32'(r_s_read), 32'h1);
    chk("t5_re_wait", 32'(r_m0_wr), 32'h0);
    next();
    m0_read = 1'b0;
    #1;
    chk("t5_end_grant", 32'(r_grant), 32'h0);

`ifdef ARB_LOCK_EN
    // Locked burst from m1 holds off m0
    idle_inputs();
    do_reset();
    m1_write = 1'b1; m1_lock = 1'b1; m1_address = 32'h80;
    next();
    m0_read = 1'b1;
    #1;
    chk("lk_grant0", 32'(r_grant), 32'h2);
    chk("lk_wait0", 32'(r_m1_wr), 32'h0);
    next();
    #1;
    chk("lk_grant1", 32'(r_grant), 32'h2);
    chk("lk_m0wait1", 32'(r_m0_wr), 32'h1);
    next();
    m1_lock = 1'b0;
    #1;
    chk("lk_grant2", 32'(r_grant), 32'h2);
    chk("lk_wait2", 32'(r_m1_wr), 32'h0);
    next();
    m1_write = 1'b0;
    #1;
    chk("lk_bubble", 32'(r_grant), 32'h0);
    next();
    #1;
    chk("lk_m0_grant", 32'(r_grant), 32'h1);
    next();
    m0_read = 1'b0;
    #1;
    chk("lk_end", 32'(r_grant), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU memory bus (address/write/read/waitrequest/writedata/byteenable/readdata, waitrequest-stalled).
- Shares a single RAM_32x4096 between master 0 (mips_cpu_bus) and master 1 (test loader / debug DMA).
- Grants one master per transaction, holds the grant until the slave completes it, and stalls the other master via its waitrequest.

Parameters:
- PRIORITY_MODE, 0, 0 = round-robin between masters; 1 = fixed priority, master 0 wins all ties.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- m0_address, m1_address  input  ADDR_W  master byte address.
- m0_read, m1_read  input  1  read request.
- m0_write, m1_write  input  1  write request.
- m0_writedata, m1_writedata  input  DATA_W  write data.
- m0_byteenable, m1_byteenable  input  DATA_W/8  byte lanes.
- m0_waitrequest, m1_waitrequest  output  1  stall to master.
- m0_readdata, m1_readdata  output  DATA_W  read data.
- s_address  output  ADDR_W  to slave.
- s_read, s_write  output  1  to slave.
- s_writedata  output  DATA_W  to slave.
- s_byteenable  output  DATA_W/8  to slave.
- s_waitrequest  input  1  from slave.
- s_readdata  input  DATA_W  from slave.
- grant  output  2  one-hot current owner (01 = m0, 10 = m1, 00 = none); debug.

Behaviour:
- Request: req_i = mi_read | mi_write. Both read and write high in one master is illegal; the arbiter forwards both unchanged.
- States and reset:
  - States: IDLE, GNT0, GNT1.
  - Async reset (reset == 0) forces IDLE and last_grant = 1, so m0 wins the first RR tie.
  - While reset is low and in IDLE: s_read = s_write = 0, grant = 00, m0/m1_waitrequest = 1.
- IDLE:
  - s_read = s_write = 0; s_address, s_writedata and s_byteenable are driven from m0 (don't-care).
  - Both waitrequests = 1.
  - Next-state choice at posedge:
    - Only req0: GNT0.
    - Only req1: GNT1.
    - Both, PRIORITY_MODE = 0: grant the master not equal to last_grant.
    - Both, PRIORITY_MODE = 1: GNT0.
    - Neither: stay in IDLE.
- GNTx:
  - s_* is combinationally muxed from master x.
  - mx_waitrequest = s_waitrequest; the other master's waitrequest = 1.
  - Completion: reqx = 1 and s_waitrequest = 0 in the same cycle. At that posedge: last_grant <= x, next state IDLE.
  - Abort: reqx drops while granted (protocol violation). Return to IDLE at the next edge without updating last_grant.
- Latency:
  - Request seen in IDLE in cycle N gives the slave strobe in cycle N+1.
  - A zero-wait slave completes in N+1, so the master sees waitrequest = 1 in N and 0 in N+1.
  - One IDLE bubble follows every transaction; peak rate is 1 transaction per 2 cycles.
- Readdata: s_readdata is broadcast to both m0_readdata and m1_readdata. It is valid only for the granted master in its completion cycle.
- Fairness: in RR mode a continuously requesting master is granted within 2 arbitration rounds.
- Reset mid-transaction: state drops to IDLE asynchronously and s_read/s_write go low in the same instant. The in-flight transaction is lost and no completion is reported.
- grant is a combinational decode of the state.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Enabled:
  - Adds inputs m0_lock and m1_lock (1 bit each).
  - If the owner completes with mx_lock = 1 and reqx = 1 in the completion cycle, the state stays GNTx with no IDLE bubble. Back-to-back locked transactions then run at 1 per cycle.
  - The other master is held off until the owner completes a transaction with lock = 0, or drops its request.
  - last_grant updates only when the grant is released.
- Disabled: no lock ports; every completion returns to IDLE.

Test Plan:
- m0 reads 0xBFC00000, zero-wait slave returning 0x8C030004 → s_read high 1 cycle after request, m0_waitrequest 1 then 0, m0_readdata = 0x8C030004, grant 00→01→00, m1_waitrequest = 1 throughout.
- m0 and m1 request simultaneously from reset, PRIORITY_MODE = 0 → m0 granted first. With both still requesting, m1 gets the next grant; 4 transactions alternate 01,10,01,10.
- Same stimulus, PRIORITY_MODE = 1 → 4 consecutive m0 grants while m0 keeps requesting; m1 granted only after m0 deasserts.
- Slave waitrequest held high 3 cycles during m1 write of 0x12345678, byteenable 4'b0011, to 0x00000010 → s_address/s_writedata/s_byteenable stable for all 4 cycles, m1_waitrequest mirrors the slave, write accepted once, m0 stalled.
- reset pulsed low in GNT0 while s_waitrequest = 1 → s_read drops immediately, grant = 00, no m0 completion; after release, m0 re-request is granted normally.
- With ARB_LOCK_EN: m1 issues 3 locked writes, the third with lock = 0, while m0 requests → grant stays 10 for 3 consecutive completion cycles, then m0 is granted.
